alu_result_stage: RTL and testbench
===================================

Name: alu_result_stage

Overview:
- Registered output stage placed directly downstream of the 8-bit combinational ALU (ADD/SUB/AND/OR with zero/carry/overflow flags).
- Captures each ALU result and its flags into a 2-entry valid/ready buffer, with optional signed saturation on ADD/SUB overflow.
- Keeps sticky carry/overflow status and a saturating overflow-event counter for software or a debug readout.
- Decouples the combinational ALU path from downstream backpressure.

Parameters:
- SAT_EN, 1, 1 = clamp overflowing ADD/SUB results to signed limits; 0 = pass results through unchanged.
- CNT_W, 8, width of the overflow-event counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  ALU output valid
- in_ready  output  1  stage can accept (not full)
- in_opcode  input  2  00=ADD 01=SUB 10=AND 11=OR
- in_result  input  8  ALU result
- in_zero  input  1  ALU zero flag
- in_carry  input  1  ALU carry/borrow flag
- in_overflow  input  1  ALU signed overflow flag
- out_valid  output  1  head entry valid
- out_ready  input  1  consumer accepts head entry
- out_result  output  8  head result (post-saturation)
- out_zero  output  1  head zero flag (recomputed)
- out_carry  output  1  head carry
- out_overflow  output  1  head overflow (original ALU flag)
- out_sat  output  1  head entry was saturated
- clr_sticky  input  1  synchronous clear of sticky flags and counter
- sticky_carry  output  1  set by any accepted entry with carry=1
- sticky_ovf  output  1  set by any accepted entry with overflow=1
- ovf_count  output  CNT_W  accepted overflow events, saturating

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values:
  - buffer empty, so out_valid=0 and in_ready=1
  - out_result, out_zero, out_carry, out_overflow and out_sat all 0
  - sticky_carry=0, sticky_ovf=0, ovf_count=0
- Reset mid-operation discards all buffered entries.
- Handshake:
  - Push when in_valid & in_ready; pop when out_valid & out_ready.
  - in_ready = (count < 2), registered from count, no combinational path from out_ready.
  - out_valid = (count != 0).
  - Output fields are driven from the head entry and stay stable while out_valid=1 and out_ready=0.
- Latency: an entry pushed at edge N appears on the outputs after edge N (visible in cycle N+1), in FIFO order.
- Throughput: 1 entry per cycle. Simultaneous push and pop at count=1 leaves count=1.
- At count=2, in_ready=0: no push, and in_valid is ignored. A pop that cycle makes in_ready=1 next cycle.
- Saturation rule, applied at push:
  - Applies when SAT_EN=1, opcode is 00 or 01, and in_overflow=1.
  - Stored result = 8'h7F if in_result[7]=1 (positive overflow wrapped negative), else 8'h80.
  - out_sat=1 for that entry.
  - Otherwise the result is stored unchanged and out_sat=0.
- Zero flag: stored zero = (stored result == 0), recomputed after saturation. in_zero is not stored.
- Flags for AND/OR: carry and overflow are stored as received.
- Sticky and counter updates happen on push only, not on pop.
  - sticky_carry |= in_carry; sticky_ovf |= in_overflow.
  - ovf_count increments by 1 on each push with in_overflow=1 and holds at 2^CNT_W-1.
- clr_sticky:
  - Alone, it zeroes sticky_carry, sticky_ovf and ovf_count next edge.
  - If it coincides with a push carrying flags, the push wins over the clear: e.g. a push with overflow gives sticky_ovf=1 and ovf_count=1.
- Two-entry FIFO: wr_ptr/rd_ptr 1 bit each, wrapping 1 to 0; count 2 bits.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams OP_ADD=2'b00, OP_SUB=2'b01, OP_AND=2'b10, OP_OR=2'b11
  - SAT_POS=8'h7F, SAT_NEG=8'h80
  - entry width constant (8 result + 4 flags = 12)
- Sub-module alu_sat: combinational saturation and zero-recompute function, also reusable by a future wider ALU.
- FIFO and sticky logic stay inline.

Test Plan:
- Reset with in_valid=1 held: in_ready=1, out_valid=0, ovf_count=0. Releasing rst_n, then one ADD push (result 0x2A) gives out_valid=1 next cycle, out_result=0x2A, out_zero=0.
- ADD 0x7F+0x01 (result 0x80, overflow=1), SAT_EN=1: out_result=0x7F, out_sat=1, out_overflow=1, out_zero=0, sticky_ovf=1, ovf_count=1. Same with SAT_EN=0: out_result=0x80, out_sat=0.
- SUB 0x80-0x01 (result 0x7F, overflow=1), SAT_EN=1: out_result=0x80. SUB 0x05-0x05: out_result=0x00, out_zero=1, carry=0.
- Backpressure: out_ready=0, push A then B, so in_ready=0 and C is held off. Then out_ready=1 yields A, B, C in order with no loss or duplication.
- Simultaneous clr_sticky with an overflow push at ovf_count=5: ovf_count=1, sticky_ovf=1. clr_sticky alone: all sticky outputs 0.
- CNT_W=2: five overflow pushes leave ovf_count=3 (saturated). AND op with carry=1 sets sticky_carry=1.

Source files
------------

// File: rtl/alu_result_stage_pkg.sv
// Shared ALU definitions: opcodes, saturation limits and the buffered entry layout.
`default_nettype none

package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  localparam int DATA_W  = 8;
  localparam int FLAG_W  = 4;
  localparam int ENTRY_W = DATA_W + FLAG_W;

  localparam logic [DATA_W-1:0] SAT_POS = 8'h7F;
  localparam logic [DATA_W-1:0] SAT_NEG = 8'h80;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic              zero;
    logic              carry;
    logic              overflow;
    logic              sat;
  } entry_t;

  function automatic logic is_arith(input logic [1:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_result_stage_sat.sv
// alu_sat: signed saturation of overflowing ADD/SUB results plus zero-flag recompute.
`default_nettype none

module alu_sat
  import alu_pkg::*;
#(
  parameter int W      = 8,
  parameter bit SAT_EN = 1'b1
) (
  input  logic [1:0]   opcode_i,
  input  logic [W-1:0] result_i,
  input  logic         overflow_i,
  output logic [W-1:0] result_o,
  output logic         zero_o,
  output logic         sat_o
);

  localparam logic [W-1:0] c_sat_pos = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] c_sat_neg = {1'b1, {(W-1){1'b0}}};

  always_comb begin
    sat_o    = SAT_EN && is_arith(opcode_i) && overflow_i;
    result_o = result_i;
    // A wrapped-negative sign bit means the true result overflowed positive.
    if (sat_o) begin
      result_o = result_i[W-1] ? c_sat_pos : c_sat_neg;
    end
    zero_o = (result_o == '0);
  end

endmodule

`default_nettype wire

// File: rtl/alu_result_stage.sv
// alu_result_stage: 2-entry registered output buffer for the ALU with saturation and sticky status.
`default_nettype none

module alu_result_stage
  import alu_pkg::*;
#(
  parameter bit SAT_EN = 1'b1,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_opcode,
  input  logic [7:0]       in_result,
  input  logic             in_zero,
  input  logic             in_carry,
  input  logic             in_overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_result,
  output logic             out_zero,
  output logic             out_carry,
  output logic             out_overflow,
  output logic             out_sat,
  input  logic             clr_sticky,
  output logic             sticky_carry,
  output logic             sticky_ovf,
  output logic [CNT_W-1:0] ovf_count
);

  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

  entry_t           mem_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       count_q, count_d;
  logic             in_ready_q;
  logic             sticky_carry_q, sticky_carry_d;
  logic             sticky_ovf_q, sticky_ovf_d;
  logic [CNT_W-1:0] ovf_count_q, ovf_count_d;

  logic             w_push, w_pop;
  logic [7:0]       w_sat_result;
  logic             w_sat_zero, w_sat_flag;
  entry_t           w_new, w_head;

  alu_sat #(
    .W      (DATA_W),
    .SAT_EN (SAT_EN)
  ) u_sat (
    .opcode_i   (in_opcode),
    .result_i   (in_result),
    .overflow_i (in_overflow),
    .result_o   (w_sat_result),
    .zero_o     (w_sat_zero),
    .sat_o      (w_sat_flag)
  );

  // in_zero is dropped: the stored zero flag must reflect the saturated value.
  assign w_new = '{result: w_sat_result, zero: w_sat_zero, carry: in_carry,
                   overflow: in_overflow, sat: w_sat_flag};

  assign w_push = in_valid & in_ready_q;
  assign w_pop  = (count_q != 2'd0) & out_ready;

  always_comb begin
    count_d = count_q;
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // A coinciding push overrides the clear so its event is not lost.
  always_comb begin
    sticky_carry_d = clr_sticky ? 1'b0 : sticky_carry_q;
    sticky_ovf_d   = clr_sticky ? 1'b0 : sticky_ovf_q;
    ovf_count_d    = clr_sticky ? '0 : ovf_count_q;
    if (w_push) begin
      sticky_carry_d = sticky_carry_d | in_carry;
      sticky_ovf_d   = sticky_ovf_d | in_overflow;
      if (in_overflow && (ovf_count_d != c_cnt_max)) begin
        ovf_count_d = ovf_count_d + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q       <= 1'b0;
      rd_ptr_q       <= 1'b0;
      count_q        <= 2'd0;
      in_ready_q     <= 1'b1;
      sticky_carry_q <= 1'b0;
      sticky_ovf_q   <= 1'b0;
      ovf_count_q    <= '0;
    end else begin
      if (w_push) begin
        mem_q[wr_ptr_q] <= w_new;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (w_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q        <= count_d;
      in_ready_q     <= (count_d != 2'd2);
      sticky_carry_q <= sticky_carry_d;
      sticky_ovf_q   <= sticky_ovf_d;
      ovf_count_q    <= ovf_count_d;
    end
  end

  assign w_head       = mem_q[rd_ptr_q];
  assign in_ready     = in_ready_q;
  assign out_valid    = (count_q != 2'd0);
  assign out_result   = w_head.result;
  assign out_zero     = w_head.zero;
  assign out_carry    = w_head.carry;
  assign out_overflow = w_head.overflow;
  assign out_sat      = w_head.sat;
  assign sticky_carry = sticky_carry_q;
  assign sticky_ovf   = sticky_ovf_q;
  assign ovf_count    = ovf_count_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: saturating, pass-through and 2-bit-counter variants side by side.
`default_nettype none

module tb_alu_result_stage;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, out_ready, clr_sticky;
  logic [1:0] in_opcode;
  logic [7:0] in_result;
  logic       in_zero, in_carry, in_overflow;

  logic       a_in_ready, a_out_valid, a_out_zero, a_out_carry, a_out_ovf, a_out_sat, a_sc, a_so;
  logic [7:0] a_out_result, a_cnt;
  logic       b_in_ready, b_out_valid, b_out_zero, b_out_carry, b_out_ovf, b_out_sat, b_sc, b_so;
  logic [7:0] b_out_result, b_cnt;
  logic       c_in_ready, c_out_valid, c_out_zero, c_out_carry, c_out_ovf, c_out_sat, c_sc, c_so;
  logic [7:0] c_out_result;
  logic [1:0] c_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_result_stage #(.SAT_EN(1'b1), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_opcode(in_opcode), .in_result(in_result), .in_zero(in_zero),
    .in_carry(in_carry), .in_overflow(in_overflow), .out_valid(a_out_valid),
    .out_ready(out_ready), .out_result(a_out_result), .out_zero(a_out_zero),
    .out_carry(a_out_carry), .out_overflow(a_out_ovf), .out_sat(a_out_sat),
    .clr_sticky(clr_sticky), .sticky_carry(a_sc), .sticky_ovf(a_so), .ovf_count(a_cnt));

  alu_result_stage #(.SAT_EN(1'b0), .CNT_W(8)) dut_nosat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_opcode(in_opcode), .in_result(in_result), .in_zero(in_zero),
    .in_carry(in_carry), .in_overflow(in_overflow), .out_valid(b_out_valid),
    .out_ready(out_ready), .out_result(b_out_result), .out_zero(b_out_zero),
    .out_carry(b_out_carry), .out_overflow(b_out_ovf), .out_sat(b_out_sat),
    .clr_sticky(clr_sticky), .sticky_carry(b_sc), .sticky_ovf(b_so), .ovf_count(b_cnt));

  alu_result_stage #(.SAT_EN(1'b1), .CNT_W(2)) dut_cnt2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(c_in_ready),
    .in_opcode(in_opcode), .in_result(in_result), .in_zero(in_zero),
    .in_carry(in_carry), .in_overflow(in_overflow), .out_valid(c_out_valid),
    .out_ready(out_ready), .out_result(c_out_result), .out_zero(c_out_zero),
    .out_carry(c_out_carry), .out_overflow(c_out_ovf), .out_sat(c_out_sat),
    .clr_sticky(clr_sticky), .sticky_carry(c_sc), .sticky_ovf(c_so), .ovf_count(c_cnt));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [7:0] res,
                       input logic z, input logic c, input logic o);
    in_opcode   = op;
    in_result   = res;
    in_zero     = z;
    in_carry    = c;
    in_overflow = o;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input logic [1:0] op, input logic [7:0] res,
                      input logic z, input logic c, input logic o);
    drive(op, res, z, c, o);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    out_ready  = 1'b0;
    clr_sticky = 1'b0;
    in_valid   = 1'b1;
    drive(OP_ADD, 8'h2A, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    chk("rst_in_ready", 32'(a_in_ready), 32'd1);
    chk("rst_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_ovf_count", 32'(a_cnt), 32'd0);
    chk("rst_out_result", 32'(a_out_result), 32'd0);
    chk("rst_sticky", 32'({a_sc, a_so, a_out_sat}), 32'd0);

    rst_n = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("first_valid", 32'(a_out_valid), 32'd1);
    chk("first_result", 32'(a_out_result), 32'h2A);
    chk("first_zero", 32'(a_out_zero), 32'd0);
    out_ready = 1'b1;
    tick();
    chk("drained", 32'(a_out_valid), 32'd0);

    // ADD 0x7F + 0x01 overflows positive
    push(OP_ADD, 8'h80, 1'b0, 1'b0, 1'b1);
    chk("addovf_result", 32'(a_out_result), 32'(SAT_POS));
    chk("addovf_sat", 32'(a_out_sat), 32'd1);
    chk("addovf_ovf", 32'(a_out_ovf), 32'd1);
    chk("addovf_zero", 32'(a_out_zero), 32'd0);
    chk("addovf_sticky", 32'(a_so), 32'd1);
    chk("addovf_cnt", 32'(a_cnt), 32'd1);
    chk("nosat_result", 32'(b_out_result), 32'h80);
    chk("nosat_sat", 32'(b_out_sat), 32'd0);

    // SUB 0x80 - 0x01 overflows negative
    push(OP_SUB, 8'h7F, 1'b0, 1'b0, 1'b1);
    chk("subovf_result", 32'(a_out_result), 32'(SAT_NEG));
    chk("subovf_sat", 32'(a_out_sat), 32'd1);
    chk("subovf_cnt", 32'(a_cnt), 32'd2);
    chk("cnt2_at2", 32'(c_cnt), 32'd2);

    push(OP_SUB, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("subzero_result", 32'(a_out_result), 32'h00);
    chk("subzero_zero", 32'(a_out_zero), 32'd1);
    chk("subzero_carry", 32'(a_out_carry), 32'd0);

    push(OP_OR, 8'h10, 1'b1, 1'b0, 1'b0);
    chk("zero_recompute", 32'(a_out_zero), 32'd0);
    tick();

    // Backpressure: fill both entries, hold off a third
    out_ready = 1'b0;
    push(OP_ADD, 8'h11, 1'b0, 1'b0, 1'b0);
    push(OP_ADD, 8'h22, 1'b0, 1'b0, 1'b0);
    chk("full_in_ready", 32'(a_in_ready), 32'd0);
    chk("full_head", 32'(a_out_result), 32'h11);
    drive(OP_ADD, 8'h33, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1;
    tick();
    chk("held_head", 32'(a_out_result), 32'h11);
    chk("held_in_ready", 32'(a_in_ready), 32'd0);
    out_ready = 1'b1;
    tick();
    chk("order_b", 32'(a_out_result), 32'h22);
    chk("reopen_in_ready", 32'(a_in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("order_c", 32'(a_out_result), 32'h33);
    chk("order_c_valid", 32'(a_out_valid), 32'd1);
    tick();
    chk("no_dup", 32'(a_out_valid), 32'd0);
    chk("sticky_carry_none", 32'(a_sc), 32'd0);

    for (int i = 0; i < 3; i++) begin
      push(OP_ADD, 8'h80, 1'b0, 1'b0, 1'b1);
    end
    chk("cnt_at5", 32'(a_cnt), 32'd5);
    chk("cnt2_saturated", 32'(c_cnt), 32'd3);

    clr_sticky = 1'b1;
    push(OP_ADD, 8'h80, 1'b0, 1'b0, 1'b1);
    chk("clr_push_cnt", 32'(a_cnt), 32'd1);
    chk("clr_push_sticky", 32'(a_so), 32'd1);
    chk("clr_push_carry", 32'(a_sc), 32'd0);
    tick();
    clr_sticky = 1'b0;
    chk("clr_alone", 32'({a_sc, a_so, a_cnt}), 32'd0);

    // AND with flags set: stored as received, never saturated
    push(OP_AND, 8'h80, 1'b0, 1'b1, 1'b1);
    chk("and_result", 32'(a_out_result), 32'h80);
    chk("and_sat", 32'(a_out_sat), 32'd0);
    chk("and_carry", 32'(a_out_carry), 32'd1);
    chk("and_sticky_carry", 32'(a_sc), 32'd1);
    chk("and_cnt", 32'(a_cnt), 32'd1);
    tick();

    out_ready = 1'b0;
    push(OP_ADD, 8'h55, 1'b0, 1'b0, 1'b0);
    chk("pre_reset_valid", 32'(a_out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midreset_valid", 32'(a_out_valid), 32'd0);
    chk("midreset_sticky", 32'({a_sc, a_cnt}), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_reset_empty", 32'(a_out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
